// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the Data_Memory arbiter and the memory it fronts.
package data_mem_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int  cand;
        logic hit;
        grant = '0;
        idx   = '0;
        cand  = 0;
        hit   = 1'b0;
        if (en) begin
            // k = NUM_REQ revisits ptr itself, so the last winner is lowest priority
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (int'(ptr) + k) % NUM_REQ;
                if (!hit && req[cand]) begin
                    hit         = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = IDX_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin front end that shares one single-port sync-read Data_Memory among NUM_REQ requesters.
//   state   | meaning
//   IDLE    | arbitrate; accept one command (req_ready pulse)
//   WRITE   | mem_wen high for one cycle with captured addr/data
//   READ    | captured address on the memory pins
//   CAPTURE | memory output valid; latched into rsp_rdata
//   RESP    | rsp_valid to granted requester until its rsp_ready
module data_memory_arbiter
    import data_mem_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]          rsp_rdata,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [WIDTH-1:0]          mem_data_in,
    output logic                      mem_wen,
    input  logic [WIDTH-1:0]          mem_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic               sel_we;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (last_q),
        .en    (state == IDLE),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign sel_addr  = req_addr[arb_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[arb_idx*WIDTH +: WIDTH];
    assign sel_we    = req_we[arb_idx];
    assign accept    = |arb_grant;

    // mem_wen decodes straight from state so it collapses the instant reset asserts
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        mem_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready = arb_grant;
                    state_nxt = sel_we ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_wen   = 1'b1;
                state_nxt = IDLE;
            end
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp_valid[gnt_idx_q] = 1'b1;
                if (rsp_ready[gnt_idx_q]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q   <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            rsp_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                last_q      <= arb_idx;
                gnt_idx_q   <= arb_idx;
                mem_address <= sel_addr;
                if (sel_we) mem_data_in <= sel_wdata;
            end
            if (state == CAPTURE) rsp_rdata <= mem_data_out;
        end
    end

endmodule
